// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller between cache ports and pipelined main memory
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        memory_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] cache_word_addr,
    output logic        write_tag_array
);

    // Counter width holds WORDS_PER_BLOCK itself; it also equals the number
    // of byte-offset bits in a block (block bytes = 2 * WORDS_PER_BLOCK).
    localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
    localparam int OB = CW;

    // Catch unusable parameterisations at elaboration time.
    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_words
        $error("WORDS_PER_BLOCK must be a power of two, at least 2");
    end
    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("MEM_LATENCY must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   issue_cnt;
    logic [CW-1:0]   recv_cnt;
    logic [15:OB]    base_hi;
    logic            issue_done;
    logic [CW-2:0]   issue_idx;
    logic            last_word;
    logic            unused_offset_bits;

    // Only the block-aligned part of the miss address is kept.
    assign unused_offset_bits = ^miss_address[OB-1:0];

    // Once all requests are out, the index pins at the last word so the
    // address bus holds its final value instead of wrapping to word 0.
    assign issue_done = issue_cnt[CW-1];
    assign issue_idx  = issue_done ? {(CW-1){1'b1}} : issue_cnt[CW-2:0];
    assign last_word  = (recv_cnt == CW'(WORDS_PER_BLOCK - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs; addresses are built by concatenation so the
    // word offset can never carry into the block-number bits.
    always_comb begin
        state_next       = state;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        cache_word_addr  = 16'h0000;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                fsm_busy        = 1'b1;
                memory_read_en  = ~issue_done;
                memory_address  = {base_hi, issue_idx, 1'b0};
                cache_word_addr = {base_hi, recv_cnt[CW-2:0], 1'b0};
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    if (last_word) begin
                        write_tag_array = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Block base latch and the independent issue / receive counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_hi   <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_hi   <= miss_address[15:OB];
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (!issue_done) begin
                        issue_cnt <= issue_cnt + CW'(1);
                    end
                    if (memory_data_valid) begin
                        recv_cnt <= recv_cnt + CW'(1);
                    end
                end
                default: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
